mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
- Shares one sequential multiplier instance between NREQ requesters, e.g. the EX stage and a second issue slot or address-generation client.
- Round-robin arbitration picks one request, latches its operands, pulses the multiplier start, waits for done and returns the product tagged with the requester id.
- Sits between the pipeline clients and the multiplier port set (start/ready/done/product).

Parameters:
- WIDTH, 4, operand width; product is 2*WIDTH.
- NREQ, 2, number of requesters (>=2).
- ID_W, $clog2(NREQ), width of the requester id.
- TIMEOUT, 2*WIDTH+4, maximum WAIT cycles; used only with MULT_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request; held with stable operands until acked.
- req_a  in  NREQ*WIDTH  packed operand A; slice i belongs to requester i.
- req_b  in  NREQ*WIDTH  packed operand B.
- req_signed  in  NREQ  per-requester signed flag.
- req_ack  out  NREQ  one-hot, one-cycle pulse; operands accepted.
- resp_valid  out  1  one-cycle pulse; result is valid.
- resp_id  out  ID_W  requester the result belongs to.
- resp_product  out  2*WIDTH  result.
- resp_err  out  1  timeout flag, valid with resp_valid; tied to 0 without the optional feature.
- busy  out  1  high in every state except IDLE.
- mult_start  out  1  multiplier start.
- mult_signed  out  1  latched signed flag.
- mult_src_a  out  WIDTH  latched operand A.
- mult_src_b  out  WIDTH  latched operand B.
- mult_ready  in  1  multiplier can accept start.
- mult_done  in  1  multiplier result valid (level).
- mult_product  in  2*WIDTH  multiplier result.

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; latched operands 0; rr pointer=NREQ-1, so requester 0 has highest priority first.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid and mult_ready: grant the first requester at or after (ptr+1) mod NREQ.
  - Same cycle: req_ack[g]=1; latch a/b/signed and id g; ptr<=g; ->ISSUE.
  - If mult_ready=0: no grant, stay in IDLE.
- ISSUE: mult_start=1 for exactly one cycle; ->WAIT.
- WAIT:
  - mult_start=0.
  - When mult_done=1: capture mult_product into resp_product; ->RESP.
  - The done seen in WAIT is always fresh, because start was consumed at the ISSUE edge.
- RESP: resp_valid=1, resp_id=latched id; ->IDLE. No new grant is made in this cycle.
- mult_src_a/b/mult_signed hold the latched values from grant until the next grant.
- Latency: ack at cycle 0, start at cycle 1, earliest resp_valid at cycle 3 (zero-operand flush case). Normal case: cycle (done cycle + 1).
- Throughput: one operation in flight; minimum 4 cycles per operation.
- Simultaneous requests: one ack per grant; losers keep req_valid asserted.
- req_valid dropped before ack: no effect; the request is simply not considered.
- Continuous requests from all requesters give strict rotation 0,1,...,NREQ-1,0.
- Zero operand: the multiplier flushes the product to 0 and reports done; the arbiter returns product 0 normally.
- Reset mid-operation: immediate return to IDLE; no resp_valid; the in-flight result is discarded. Requesters must re-issue.
- No arithmetic is done here; product width is 2*WIDTH, passed through unchanged.

Optional Feature:
- Macro: MULT_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit WAIT-cycle counter clears on entry to WAIT.
  - If the count reaches TIMEOUT without mult_done: go to RESP with resp_product=0 and resp_err=1.
  - resp_err=0 on normal completion.
- Undefined: no counter; WAIT waits indefinitely; resp_err is constant 0.

Decomposition:
- Package mult_arb_pkg: state enum (IDLE=0, ISSUE=1, WAIT=2, RESP=3) and a clog2 helper for ID_W.
- Sub-module rr_arbiter #(NREQ): inputs req vector, ptr and enable; outputs one-hot grant and encoded index. Purely combinational; the pointer register lives in mult_arbiter.

Test Plan:
- Single request: req0 with a=3, b=5 -> ack0 at cycle 0, mult_start at cycle 1, resp_valid with id=0 and product=8'h0F.
- Zero operand: req1 with a=0, b=7 -> resp_valid at cycle 3, id=1, product=0.
- Simultaneous start: req0 and req1 both asserted after reset -> grant order 0 then 1; products 2*3=6 then 4*4=16 with the matching ids.
- Fairness: both requesters held for 6 operations -> ack sequence 0,1,0,1,0,1; no back-to-back grant to the same requester.
- Reset asserted in WAIT -> busy=0 and all outputs 0 immediately; no resp_valid; next request completes normally.
- MULT_ARB_TIMEOUT_EN with a stub holding mult_done=0 -> resp_valid and resp_err=1 exactly TIMEOUT cycles after entering WAIT, product=0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int unsigned TMO_CNT_W = 8;

    // Width needed to encode n requester ids; never less than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr+1 wins.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    logic            hit_c;
    logic [ID_W-1:0] cand_c;

    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        hit_c  = 1'b0;
        cand_c = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand_c = ID_W'((32'(ptr_i) + k) % NREQ);
            if (en_i && !hit_c && req_i[cand_c]) begin
                hit_c         = 1'b1;
                gnt_o[cand_c] = 1'b1;
                idx_o         = cand_c;
            end
        end
    end

    assign any_o = hit_c;

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier between NREQ requesters with round-robin grant.
// Optional WAIT timeout (resp_err) enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned ID_W    = id_width(NREQ),
    parameter int unsigned TIMEOUT = 2 * WIDTH + 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_signed,
    output logic [NREQ-1:0]       req_ack,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [2*WIDTH-1:0]    resp_product,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  mult_start,
    output logic                  mult_signed,
    output logic [WIDTH-1:0]      mult_src_a,
    output logic [WIDTH-1:0]      mult_src_b,
    input  logic                  mult_ready,
    input  logic                  mult_done,
    input  logic [2*WIDTH-1:0]    mult_product
);

    localparam int unsigned PW = 2 * WIDTH;

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic            sgn_q, sgn_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic            start_q, resp_valid_q, busy_q;

    logic            arb_en_c;
    logic [NREQ-1:0] gnt_c;
    logic [ID_W-1:0] gnt_idx_c;
    logic            gnt_any_c;
    logic [WIDTH-1:0] sel_a_c, sel_b_c;
    logic            sel_s_c;
    logic            tmo_hit_c;

    // Grants only from IDLE with a ready multiplier; reset masks the ack.
    assign arb_en_c = (state_q == IDLE) && mult_ready && !reset;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (arb_en_c),
        .gnt_o (gnt_c),
        .idx_o (gnt_idx_c),
        .any_o (gnt_any_c)
    );

    // One-hot operand mux of the granted requester.
    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        sel_s_c = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                sel_a_c = req_a[i*WIDTH +: WIDTH];
                sel_b_c = req_b[i*WIDTH +: WIDTH];
                sel_s_c = req_signed[i];
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

    logic [TMO_CNT_W-1:0] tmo_q, tmo_d;
    logic                 err_q, err_d;

    assign tmo_hit_c = (state_q == WAIT) && !mult_done && (tmo_q == TMO_LAST);

    // Counts WAIT cycles; cleared in ISSUE so it starts at zero on WAIT entry.
    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (state_q == ISSUE) begin
            tmo_d = '0;
        end else if (state_q == WAIT) begin
            if (mult_done) begin
                err_d = 1'b0;
            end else if (tmo_hit_c) begin
                err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign resp_err = err_q;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT);
    assign tmo_hit_c      = 1'b0;
    assign resp_err       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (gnt_any_c) begin
                    ptr_d   = gnt_idx_c;
                    id_d    = gnt_idx_c;
                    a_d     = sel_a_c;
                    b_d     = sel_b_c;
                    sgn_d   = sel_s_c;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // done here is fresh: the multiplier consumed start at the ISSUE edge.
                if (mult_done) begin
                    prod_d  = mult_product;
                    state_d = RESP;
                end else if (tmo_hit_c) begin
                    prod_d  = '0;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= ID_W'(NREQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sgn_q        <= 1'b0;
            prod_q       <= '0;
            start_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sgn_q        <= sgn_d;
            prod_q       <= prod_d;
            start_q      <= (state_d == ISSUE);
            resp_valid_q <= (state_d == RESP);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign req_ack      = gnt_c;
    assign resp_valid   = resp_valid_q;
    assign resp_id      = id_q;
    assign resp_product = prod_q;
    assign busy         = busy_q;
    assign mult_start   = start_q;
    assign mult_signed  = sgn_q;
    assign mult_src_a   = a_q;
    assign mult_src_b   = b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: stub multiplier plus a transaction-level reference model.
module tb_mult_arbiter;

    localparam int WIDTH   = 4;
    localparam int NREQ    = 2;
    localparam int ID_W    = 1;
    localparam int PW      = 2 * WIDTH;
    localparam int TIMEOUT = 2 * WIDTH + 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       req_signed = '0;
    logic [NREQ-1:0]       req_ack;
    logic                  resp_valid;
    logic [ID_W-1:0]       resp_id;
    logic [PW-1:0]         resp_product;
    logic                  resp_err;
    logic                  busy;
    logic                  mult_start;
    logic                  mult_signed;
    logic [WIDTH-1:0]      mult_src_a;
    logic [WIDTH-1:0]      mult_src_b;
    logic                  mult_ready = 1'b1;
    logic                  mult_done = 1'b0;
    logic [PW-1:0]         mult_product = '0;

    always #5 clk = ~clk;

    mult_arbiter #(
        .WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
        .req_ack(req_ack), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_product(resp_product), .resp_err(resp_err), .busy(busy),
        .mult_start(mult_start), .mult_signed(mult_signed),
        .mult_src_a(mult_src_a), .mult_src_b(mult_src_b),
        .mult_ready(mult_ready), .mult_done(mult_done), .mult_product(mult_product)
    );

    function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic s);
        int x, y;
        x = int'(a);
        y = int'(b);
        if (s && a[WIDTH-1]) x = x - (1 << WIDTH);
        if (s && b[WIDTH-1]) y = y - (1 << WIDTH);
        return PW'(x * y);
    endfunction

    // Stub multiplier: start clears done; zero operand flushes immediately.
    int          stub_lat = 3;
    bit          stub_hang = 0;
    int          stub_cnt = 0;
    logic [PW-1:0] stub_pend = '0;

    always @(posedge clk) begin
        if (mult_start) begin
            if (mult_src_a == '0 || mult_src_b == '0) begin
                mult_done    <= 1'b1;
                mult_product <= '0;
                stub_cnt     <= 0;
            end else begin
                mult_done <= 1'b0;
                stub_cnt  <= stub_lat;
                stub_pend <= ref_mul(mult_src_a, mult_src_b, mult_signed);
            end
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && !stub_hang) begin
                mult_done    <= 1'b1;
                mult_product <= stub_pend;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state (transaction level)
    bit            in_flight = 0;
    int            ack_cyc = 0;
    int            resp_cyc = 0;
    int            m_ptr = NREQ - 1;
    int            m_id = 0;
    logic [PW-1:0] m_prod = '0;
    bit            m_err = 0;
    logic [WIDTH-1:0] m_a = '0, m_b = '0;
    logic          m_s = 1'b0;

    bit               cl_pend[NREQ];
    logic [WIDTH-1:0] cl_a[NREQ];
    logic [WIDTH-1:0] cl_b[NREQ];
    logic             cl_s[NREQ];
    bit               auto_mode = 0;
    bit               hold_mode = 0;

    int            gnt_log[$];
    int            rid_log[$];
    logic [PW-1:0] rprod_log[$];
    int            lat_log[$];

    function automatic bit any_pend();
        for (int i = 0; i < NREQ; i++) if (cl_pend[i]) return 1;
        return 0;
    endfunction

    task automatic new_req(input int i);
        cl_pend[i] = 1;
        cl_a[i] = WIDTH'($urandom);
        cl_b[i] = WIDTH'($urandom);
        cl_s[i] = 1'($urandom);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]                 = cl_pend[i];
            req_a[i*WIDTH +: WIDTH]      = cl_a[i];
            req_b[i*WIDTH +: WIDTH]      = cl_b[i];
            req_signed[i]                = cl_s[i];
        end
    endtask

    task automatic clear_logs();
        gnt_log.delete(); rid_log.delete(); rprod_log.delete(); lat_log.delete();
    endtask

    task automatic check_cycle();
        logic [NREQ-1:0] exp_ack;
        int              g;
        bit              resp_now;
        exp_ack  = '0;
        g        = -1;
        resp_now = in_flight && (resp_cyc == cyc);
        chk("busy", 32'(busy), 32'(in_flight));
        if (!in_flight && mult_ready) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (g < 0 && cl_pend[c]) g = c;
            end
        end
        if (g >= 0) exp_ack[g] = 1'b1;
        chk("req_ack", 32'(req_ack), 32'(exp_ack));
        chk("mult_start", 32'(mult_start), 32'(in_flight && cyc == ack_cyc + 1));
        chk("resp_valid", 32'(resp_valid), 32'(resp_now));
        chk("src_a", 32'(mult_src_a), 32'(m_a));
        chk("src_b", 32'(mult_src_b), 32'(m_b));
        chk("src_signed", 32'(mult_signed), 32'(m_s));
        if (resp_now) begin
            chk("resp_id", 32'(resp_id), 32'(m_id));
            chk("resp_product", 32'(resp_product), m_err ? 32'd0 : 32'(m_prod));
            chk("resp_err", 32'(resp_err), 32'(m_err));
            rid_log.push_back(int'(resp_id));
            rprod_log.push_back(resp_product);
            lat_log.push_back(cyc - ack_cyc);
            in_flight = 0;
        end else if (in_flight && resp_cyc == 0 && cyc >= ack_cyc + 2) begin
            if (mult_done) begin
                resp_cyc = cyc + 1;
                m_err    = 0;
            end
`ifdef MULT_ARB_TIMEOUT_EN
            else if (cyc == ack_cyc + 1 + TIMEOUT) begin
                resp_cyc = cyc + 1;
                m_err    = 1;
            end
`endif
        end
        if (g >= 0) begin
            in_flight  = 1;
            ack_cyc    = cyc;
            resp_cyc   = 0;
            m_ptr      = g;
            m_id       = g;
            m_a        = cl_a[g];
            m_b        = cl_b[g];
            m_s        = cl_s[g];
            m_prod     = ref_mul(cl_a[g], cl_b[g], cl_s[g]);
            cl_pend[g] = 0;
            gnt_log.push_back(g);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            if (hold_mode && !cl_pend[i]) new_req(i);
            if (auto_mode) begin
                if (!cl_pend[i] && $urandom_range(0, 3) == 0) new_req(i);
                else if (cl_pend[i] && $urandom_range(0, 15) == 0) cl_pend[i] = 0;
            end
        end
        if (auto_mode) begin
            mult_ready = ($urandom_range(0, 4) != 0);
            stub_lat   = $urandom_range(1, 6);
        end else begin
            mult_ready = 1'b1;
        end
        drive_reqs();
        #1;
        check_cycle();
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        while ((in_flight || any_pend()) && n < max_cyc) begin
            cycle();
            n++;
        end
        chk("idle_bound", 32'(in_flight || any_pend()), 32'd0);
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        #1;
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(mult_start), 32'd0);
        chk("rst_src_a", 32'(mult_src_a), 32'd0);
        chk("rst_src_b", 32'(mult_src_b), 32'd0);
        chk("rst_signed", 32'(mult_signed), 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        chk("rst_product", 32'(resp_product), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        in_flight = 0; resp_cyc = 0; m_ptr = NREQ - 1;
        m_a = '0; m_b = '0; m_s = 1'b0;
        for (int i = 0; i < NREQ; i++) cl_pend[i] = 0;
        drive_reqs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input int a, input int b, input bit s);
        cl_pend[i] = 1;
        cl_a[i] = WIDTH'(a);
        cl_b[i] = WIDTH'(b);
        cl_s[i] = s;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            cl_pend[i] = 0; cl_a[i] = '0; cl_b[i] = '0; cl_s[i] = 1'b0;
        end
        do_reset();

        // Single request 3*5
        clear_logs();
        stub_lat = 3;
        set_req(0, 3, 5, 0);
        run_until_idle(40);
        chk("single_n", 32'(rid_log.size()), 32'd1);
        if (rid_log.size() == 1) begin
            chk("single_id", 32'(rid_log[0]), 32'd0);
            chk("single_prod", 32'(rprod_log[0]), 32'h0F);
        end

        // Zero operand flush: response 3 cycles after ack
        clear_logs();
        set_req(1, 0, 7, 0);
        run_until_idle(40);
        chk("zero_n", 32'(rid_log.size()), 32'd1);
        if (rid_log.size() == 1) begin
            chk("zero_id", 32'(rid_log[0]), 32'd1);
            chk("zero_prod", 32'(rprod_log[0]), 32'd0);
            chk("zero_lat", 32'(lat_log[0]), 32'd3);
        end

        // Simultaneous requests straight after reset
        do_reset();
        clear_logs();
        set_req(0, 2, 3, 0);
        set_req(1, 4, 4, 0);
        run_until_idle(60);
        chk("simul_n", 32'(rid_log.size()), 32'd2);
        if (rid_log.size() == 2) begin
            chk("simul_g0", 32'(gnt_log[0]), 32'd0);
            chk("simul_g1", 32'(gnt_log[1]), 32'd1);
            chk("simul_id0", 32'(rid_log[0]), 32'd0);
            chk("simul_p0", 32'(rprod_log[0]), 32'd6);
            chk("simul_id1", 32'(rid_log[1]), 32'd1);
            chk("simul_p1", 32'(rprod_log[1]), 32'd16);
        end

        // Fairness under continuous requests
        do_reset();
        clear_logs();
        hold_mode = 1;
        for (int n = 0; n < 200 && gnt_log.size() < 6; n++) cycle();
        hold_mode = 0;
        run_until_idle(60);
        chk("fair_n", 32'(gnt_log.size() >= 6), 32'd1);
        if (gnt_log.size() >= 6)
            for (int i = 0; i < 6; i++) chk("fair_order", 32'(gnt_log[i]), 32'(i % 2));

        // Reset while waiting for done
        clear_logs();
        stub_lat = 6;
        set_req(0, 5, 5, 0);
        for (int n = 0; n < 20 && !(in_flight && cyc >= ack_cyc + 2); n++) cycle();
        chk("wait_reached", 32'(in_flight && cyc >= ack_cyc + 2), 32'd1);
        do_reset();
        for (int n = 0; n < 10; n++) cycle();
        chk("rst_no_resp", 32'(rid_log.size()), 32'd0);
        stub_lat = 2;
        set_req(1, 7, 3, 0);
        run_until_idle(40);
        chk("post_rst_n", 32'(rid_log.size()), 32'd1);
        if (rid_log.size() == 1) begin
            chk("post_rst_id", 32'(rid_log[0]), 32'd1);
            chk("post_rst_p", 32'(rprod_log[0]), 32'd21);
        end

`ifdef MULT_ARB_TIMEOUT_EN
        // Hung multiplier: timeout response after TIMEOUT WAIT cycles
        do_reset();
        clear_logs();
        stub_hang = 1;
        set_req(0, 3, 3, 0);
        run_until_idle(80);
        stub_hang = 0;
        chk("tmo_n", 32'(lat_log.size()), 32'd1);
        if (lat_log.size() == 1) begin
            chk("tmo_lat", 32'(lat_log[0]), 32'(TIMEOUT + 2));
            chk("tmo_prod", 32'(rprod_log[0]), 32'd0);
        end
`endif

        // Randomized traffic, signed and unsigned, with ready gaps and withdrawals
        clear_logs();
        auto_mode = 1;
        for (int n = 0; n < 1500; n++) cycle();
        auto_mode = 0;
        for (int i = 0; i < NREQ; i++) cl_pend[i] = 0;
        run_until_idle(60);
        chk("rand_traffic", 32'(rid_log.size() > 50), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
